// File: rtl/wb_trace_checker.sv
// Writeback-trace monitor: compares each retired writeback against a preloaded expected trace.
// Optional define WB_TRACE_PC_CHECK_EN adds an exp_pc MSB field to each entry and checks pc too.
module wb_trace_checker #(
   parameter int XLEN    = 32,
   parameter int DEPTH   = 64,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 16,
`ifdef WB_TRACE_PC_CHECK_EN
   localparam int EW     = 2*XLEN + 8,
`else
   localparam int EW     = XLEN + 8,
`endif
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             exp_wr_en,
   input  logic [AW-1:0]    exp_wr_addr,
   input  logic [EW-1:0]    exp_wr_data,
   input  logic             retire_valid,
   input  logic             reg_write,
   input  logic [4:0]       reg_waddr,
   input  logic [XLEN-1:0]  reg_wdata,
   input  logic [XLEN-1:0]  pc,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             fail,
   output logic             timeout,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] retired_count,
   output logic [AW-1:0]    fail_index,
   output logic [XLEN-1:0]  fail_pc,
   output logic [XLEN-1:0]  fail_got,
   output logic [XLEN-1:0]  fail_exp
);

   localparam int IW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state;
   logic [EW-1:0]   mem [DEPTH];
   logic [AW-1:0]   idx;
   logic [IW-1:0]   idle_cnt;

   logic [EW-1:0]   entry;
   logic [XLEN-1:0] e_wdata;
   logic [4:0]      e_waddr;
   logic            e_we, e_care, e_last;
   logic            mismatch, is_last;

   always_comb begin
      entry    = mem[idx];
      e_wdata  = entry[XLEN-1:0];
      e_waddr  = entry[XLEN+4:XLEN];
      e_we     = entry[XLEN+5];
      e_care   = entry[XLEN+6];
      e_last   = entry[XLEN+7];
      mismatch = (reg_write != e_we) || (reg_waddr != e_waddr) ||
                 (e_care && (reg_wdata != e_wdata));
`ifdef WB_TRACE_PC_CHECK_EN
      mismatch = mismatch || (pc != entry[EW-1 -: XLEN]);
`endif
      // The final slot ends the run even without its last flag, so idx never wraps.
      is_last  = e_last || (idx == AW'(DEPTH - 1));
   end

   // Trace storage survives reset so a rerun needs no reload.
   always_ff @(posedge clk) begin
      if (exp_wr_en && state != RUN)
         mem[exp_wr_addr] <= exp_wr_data;
   end

   assign busy = (state == RUN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         idx           <= '0;
         idle_cnt      <= '0;
         done          <= 1'b0;
         pass          <= 1'b0;
         fail          <= 1'b0;
         timeout       <= 1'b0;
         err_count     <= '0;
         retired_count <= '0;
         fail_index    <= '0;
         fail_pc       <= '0;
         fail_got      <= '0;
         fail_exp      <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state         <= RUN;
                  idx           <= '0;
                  idle_cnt      <= '0;
                  done          <= 1'b0;
                  pass          <= 1'b0;
                  fail          <= 1'b0;
                  timeout       <= 1'b0;
                  err_count     <= '0;
                  retired_count <= '0;
                  fail_index    <= '0;
                  fail_pc       <= '0;
                  fail_got      <= '0;
                  fail_exp      <= '0;
               end
            end
            RUN: begin
               if (retire_valid) begin
                  idle_cnt <= '0;
                  if (retired_count != '1)
                     retired_count <= retired_count + 1'b1;
                  if (mismatch) begin
                     if (err_count != '1)
                        err_count <= err_count + 1'b1;
                     if (err_count == '0) begin
                        fail_index <= idx;
                        fail_pc    <= pc;
                        fail_got   <= reg_wdata;
                        fail_exp   <= e_wdata;
                     end
                  end
                  if (is_last) begin
                     state <= DONE;
                     done  <= 1'b1;
                     fail  <= mismatch || (err_count != '0);
                     pass  <= !(mismatch || (err_count != '0));
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end else if (idle_cnt == IW'(TIMEOUT - 1)) begin
                  state   <= DONE;
                  done    <= 1'b1;
                  timeout <= 1'b1;
                  fail    <= 1'b1;
                  pass    <= 1'b0;
               end else begin
                  idle_cnt <= idle_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_trace_checker.sv
// Randomized scoreboard bench for wb_trace_checker; a trace-walking model predicts each run's verdict.
module tb_wb_trace_checker;

   localparam int XLEN    = 32;
   localparam int DEPTH   = 16;
   localparam int TIMEOUT = 4;
   localparam int CNT_W   = 16;
   localparam int AW      = $clog2(DEPTH);
`ifdef WB_TRACE_PC_CHECK_EN
   localparam int EW      = 2*XLEN + 8;
`else
   localparam int EW      = XLEN + 8;
`endif

   logic             clk = 1'b0;
   logic             rst, start, exp_wr_en;
   logic [AW-1:0]    exp_wr_addr;
   logic [EW-1:0]    exp_wr_data;
   logic             retire_valid, reg_write;
   logic [4:0]       reg_waddr;
   logic [XLEN-1:0]  reg_wdata, pc;
   logic             busy, done, pass, fail, timeout;
   logic [CNT_W-1:0] err_count, retired_count;
   logic [AW-1:0]    fail_index;
   logic [XLEN-1:0]  fail_pc, fail_got, fail_exp;

   wb_trace_checker #(.XLEN(XLEN), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .exp_wr_en(exp_wr_en),
      .exp_wr_addr(exp_wr_addr), .exp_wr_data(exp_wr_data),
      .retire_valid(retire_valid), .reg_write(reg_write), .reg_waddr(reg_waddr),
      .reg_wdata(reg_wdata), .pc(pc), .busy(busy), .done(done), .pass(pass),
      .fail(fail), .timeout(timeout), .err_count(err_count),
      .retired_count(retired_count), .fail_index(fail_index), .fail_pc(fail_pc),
      .fail_got(fail_got), .fail_exp(fail_exp));

   always #5 clk = ~clk;

   typedef struct {
      int             gap;
      bit             rw;
      bit [4:0]       wa;
      bit [XLEN-1:0]  wd;
      bit [XLEN-1:0]  pc;
   } retire_t;

   typedef struct {
      bit             timeout;
      bit             fail;
      int             err;
      int             ret;
      int             fidx;
      bit [XLEN-1:0]  fpc;
      bit [XLEN-1:0]  fgot;
      bit [XLEN-1:0]  fexp;
   } res_t;

   res_t          exp_q[$];
   res_t          mon_r;
   bit [EW-1:0]   mdl_mem [DEPTH];
   int            tests = 0;
   int            fails = 0;
   logic          prev_done = 1'b0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   function automatic bit [EW-1:0] mk(bit last, bit care, bit we, bit [4:0] wa,
                                      bit [XLEN-1:0] wd, bit [XLEN-1:0] epc);
`ifdef WB_TRACE_PC_CHECK_EN
      return {epc, last, care, we, wa, wd};
`else
      return {last, care, we, wa, wd};
`endif
   endfunction

   // Walk the expected trace in retire order; a gap of TIMEOUT idle cycles ends the run.
   function automatic res_t model(input retire_t it[$], output int used);
      res_t        r;
      int          ix;
      bit [EW-1:0] e;
      bit          bad;
      r    = '{default: 0};
      ix   = 0;
      used = it.size();
      foreach (it[i]) begin
         if (it[i].gap >= TIMEOUT) begin
            r.timeout = 1; r.fail = 1; used = i;
            return r;
         end
         e = mdl_mem[ix];
         r.ret++;
         bad = (it[i].rw != e[XLEN+5]) || (it[i].wa != e[XLEN+4:XLEN]) ||
               (e[XLEN+6] && it[i].wd != e[XLEN-1:0]);
`ifdef WB_TRACE_PC_CHECK_EN
         bad = bad || (it[i].pc != e[EW-1 -: XLEN]);
`endif
         if (bad) begin
            if (r.err == 0) begin
               r.fidx = ix; r.fpc = it[i].pc; r.fgot = it[i].wd; r.fexp = e[XLEN-1:0];
            end
            r.err++;
            r.fail = 1;
         end
         if (e[XLEN+7] || ix == DEPTH-1) begin
            used = i + 1;
            return r;
         end
         ix++;
      end
      r.timeout = 1; r.fail = 1;
      return r;
   endfunction

   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic load(input int a, input bit [EW-1:0] d);
      exp_wr_en = 1'b1; exp_wr_addr = AW'(a); exp_wr_data = d;
      mdl_mem[a] = d;
      tick;
      exp_wr_en = 1'b0;
   endtask

   task automatic drive_retire(input retire_t x);
      retire_valid = 1'b1; reg_write = x.rw; reg_waddr = x.wa; reg_wdata = x.wd; pc = x.pc;
      tick;
      retire_valid = 1'b0; exp_wr_en = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_flags"}, 64'({busy, done, pass, fail, timeout}), 64'(0));
      check({tag, "_counts"}, 64'({err_count, retired_count}), 64'(0));
      check({tag, "_fidx"}, 64'(fail_index), 64'(0));
      check({tag, "_fpc"}, 64'(fail_pc), 64'(0));
      check({tag, "_fgot_fexp"}, {fail_got, fail_exp}, 64'(0));
   endtask

   // wr_start: entry wa is written in the same cycle as start (model already updated).
   // mid_wr: a write attempted in the first RUN cycle, which must be ignored.
   task automatic drive_run(input retire_t it[$], input bit wr_start, input int wa,
                            input bit mid_wr, output res_t r);
      int used;
      int n;
      if (wr_start) begin
         exp_wr_en = 1'b1; exp_wr_addr = AW'(wa); exp_wr_data = mdl_mem[wa];
      end
      start = 1'b1;
      tick;
      start = 1'b0; exp_wr_en = 1'b0;
      r = model(it, used);
      exp_q.push_back(r);
      if (mid_wr) begin
         exp_wr_en = 1'b1; exp_wr_addr = AW'(1); exp_wr_data = ~mdl_mem[1];
      end
      for (int i = 0; i < used; i++) begin
         for (int g = 0; g < it[i].gap; g++) begin
            tick;
            exp_wr_en = 1'b0;
         end
         drive_retire(it[i]);
      end
      exp_wr_en = 1'b0;
      n = 0;
      while (!done && n < 4*TIMEOUT + 8) begin
         tick;
         n++;
      end
      check("done_latency", 64'(n), r.timeout ? 64'(TIMEOUT) : 64'(0));
      // Retires after the run must not be consumed.
      for (int k = 0; k < 2; k++) begin
         retire_valid = 1'($urandom_range(0, 1)); reg_write = 1'b1;
         tick;
      end
      retire_valid = 1'b0;
      check("post_done_hold", 64'({done, busy, retired_count}), 64'({1'b1, 1'b0, CNT_W'(r.ret)}));
   endtask

   function automatic retire_t match(input int ix, input int gap);
      retire_t     x;
      bit [EW-1:0] e;
      e    = mdl_mem[ix];
      x.gap = gap;
      x.rw  = e[XLEN+5];
      x.wa  = e[XLEN+4:XLEN];
      x.wd  = e[XLEN+6] ? e[XLEN-1:0] : $urandom;
`ifdef WB_TRACE_PC_CHECK_EN
      x.pc  = e[EW-1 -: XLEN];
`else
      x.pc  = $urandom;
`endif
      return x;
   endfunction

   always @(negedge clk) begin
      check("pass_fail_excl", 64'(pass & fail), 64'(0));
      if (!done)
         check("verdict_idle", 64'({pass, fail, timeout}), 64'(0));
      if (done && !prev_done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 64'(1), 64'(0));
         end else begin
            mon_r = exp_q.pop_front();
            check("timeout", 64'(timeout), 64'(mon_r.timeout));
            check("fail", 64'(fail), 64'(mon_r.fail));
            check("pass", 64'(pass), 64'(!mon_r.fail));
            check("err_count", 64'(err_count), 64'(mon_r.err));
            check("retired_count", 64'(retired_count), 64'(mon_r.ret));
            check("fail_index", 64'(fail_index), 64'(mon_r.fidx));
            check("fail_pc", 64'(fail_pc), 64'(mon_r.fpc));
            check("fail_got", 64'(fail_got), 64'(mon_r.fgot));
            check("fail_exp", 64'(fail_exp), 64'(mon_r.fexp));
         end
      end
      prev_done <= done;
   end

   initial begin
      retire_t its[$];
      retire_t x;
      res_t    r;
      int      len;
      bit      nolast, wr_start;
      int      nload;

      rst = 1'b1; start = 1'b0; exp_wr_en = 1'b0; exp_wr_addr = '0; exp_wr_data = '0;
      retire_valid = 1'b0; reg_write = 1'b0; reg_waddr = '0; reg_wdata = '0; pc = '0;
      tick;
      check_zero("reset");
      rst = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         load(i, mk(1'b0, 1'b1, 1'b1, 5'(i), $urandom, $urandom));

      // Three-entry trace, all matching.
      load(0, mk(1'b0, 1'b1, 1'b1, 5'd1, 32'h3E8, 32'h100));
      load(1, mk(1'b0, 1'b1, 1'b1, 5'd2, 32'h3C0, 32'h104));
      load(2, mk(1'b1, 1'b1, 1'b1, 5'd3, 32'h3E8, 32'h108));
      its = '{match(0, 0), match(1, 0), match(2, 0)};
      drive_run(its, 1'b0, 0, 1'b0, r);
      check("pass_run_pass", 64'(pass), 64'(1));

      // One bad data value, then two.
      its[1].wd = 32'h3C1;
      drive_run(its, 1'b0, 0, 1'b0, r);
      its[2].wd = 32'h111;
      drive_run(its, 1'b0, 0, 1'b0, r);
      check("first_err_kept", 64'({fail_index, fail_got}), 64'({AW'(1), 32'h3C1}));

      // Timeout with no retires, then a retire at cycle 4 delaying it.
      its.delete();
      drive_run(its, 1'b0, 0, 1'b0, r);
      its = '{match(0, 3)};
      drive_run(its, 1'b0, 0, 1'b0, r);

      // Abort mid-run, rerun without reload; a write during RUN must be dropped.
      start = 1'b1; tick; start = 1'b0;
      drive_retire(match(0, 0));
      drive_retire(match(1, 0));
      rst = 1'b1; #1;
      check_zero("midrun_rst");
      tick;
      rst = 1'b0;
      its = '{match(0, 1), match(1, 0), match(2, 0)};
      drive_run(its, 1'b0, 0, 1'b1, r);
      check("rerun_pass", 64'(pass), 64'(1));

      // Store entry: write enable and address checked, data ignored.
      load(0, mk(1'b1, 1'b0, 1'b0, 5'd8, 32'h0, 32'h200));
      x = match(0, 0); x.wd = 32'hDEAD;
      its = '{x};
      drive_run(its, 1'b0, 0, 1'b0, r);
      x.rw = 1'b1;
      its = '{x};
      drive_run(its, 1'b0, 0, 1'b0, r);

      // PC differs from exp_pc with matching data.
      load(0, mk(1'b1, 1'b1, 1'b1, 5'd4, 32'h55, 32'h80));
      x = match(0, 0); x.pc = 32'h84;
      its = '{x};
      drive_run(its, 1'b0, 0, 1'b0, r);

      // Random traces, including no-last traces that end at the final slot.
      for (int run = 0; run < 40; run++) begin
         len      = $urandom_range(1, DEPTH);
         nolast   = ($urandom_range(0, 4) == 0);
         wr_start = $urandom_range(0, 1);
         nload    = nolast ? DEPTH : len;
         for (int i = 0; i < nload; i++) begin
            x.wd = $urandom; x.pc = $urandom;
            if (wr_start && i == nload - 1)
               mdl_mem[i] = mk(!nolast && i == len-1, $urandom_range(0, 4) != 0,
                               1'($urandom_range(0, 1)), 5'($urandom), x.wd, x.pc);
            else
               load(i, mk(!nolast && i == len-1, $urandom_range(0, 4) != 0,
                          1'($urandom_range(0, 1)), 5'($urandom), x.wd, x.pc));
         end
         its.delete();
         for (int i = 0; i < nload; i++) begin
            x = match(i, ($urandom_range(0, 14) == 0) ? TIMEOUT : $urandom_range(0, TIMEOUT-1));
            if ($urandom_range(0, 3) == 0) begin
               case ($urandom_range(0, 3))
                  0: x.rw = ~x.rw;
                  1: x.wa = x.wa ^ 5'($urandom_range(1, 31));
                  2: x.wd = x.wd ^ $urandom_range(1, 255);
                  default: x.pc = x.pc ^ 32'h4;
               endcase
            end
            its.push_back(x);
         end
         drive_run(its, wr_start, nload - 1, $urandom_range(0, 1), r);
      end

      repeat (3) tick;
      check("queue_drained", 64'(exp_q.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
